uart_rx_drain_ctrl: RTL and testbench

Sequences reads from the UART receiver FIFO and hands bytes to a downstream valid/ready sink, such as a DMA or a byte-stream consumer. A burst starts when the FIFO reaches its trigger level, or when the character-timeout counter expires with data still queued. The block drives the FIFO pop, splits each record into data and line-status bits, and raises the data-ready and timeout interrupt indications. It sits between uart_receiver (rf_* / counter_t outputs) and the register/DMA side.

---
 rtl/uart_rx_drain_ctrl_pkg.sv | 32 +++
 rtl/uart_rx_errstat.sv | 34 +++
 rtl/uart_rx_drain_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_drain_ctrl_pkg.sv
// Shared constants for the UART receive drain controller: state encodings,
// trigger thresholds and the FIFO record field layout.
package uart_rx_drain_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    localparam logic [3:0] THR_L0 = 4'd1;
    localparam logic [3:0] THR_L1 = 4'd4;
    localparam logic [3:0] THR_L2 = 4'd8;
    localparam logic [3:0] THR_L3 = 4'd14;

    // Record layout: {data[7:0], break, parity_err, framing_err}
    localparam int REC_DATA_HI = 10;
    localparam int REC_DATA_LO = 3;
    localparam int REC_BRK     = 2;
    localparam int REC_PAR     = 1;
    localparam int REC_FRM     = 0;

    function automatic logic [3:0] trig_thr(input logic [1:0] lvl);
        logic [3:0] t;
        case (lvl)
            2'd0:    t = THR_L0;
            2'd1:    t = THR_L1;
            2'd2:    t = THR_L2;
            default: t = THR_L3;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_errstat.sv
// Saturating per-class receive error counters; only present in builds that
// define UART_RX_DRAIN_ERRSTAT_EN.
`ifdef UART_RX_DRAIN_ERRSTAT_EN
module uart_rx_errstat (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] err,
    output logic [7:0] cnt_break,
    output logic [7:0] cnt_parity,
    output logic [7:0] cnt_framing
);
    import uart_rx_drain_ctrl_pkg::*;

    logic [2:0][7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            for (int i = 0; i < 3; i++) begin
                if (err[i] && (r_cnt[i] != 8'hFF))
                    r_cnt[i] <= r_cnt[i] + 8'd1;
            end
        end
    end

    assign cnt_break   = r_cnt[REC_BRK];
    assign cnt_parity  = r_cnt[REC_PAR];
    assign cnt_framing = r_cnt[REC_FRM];

endmodule
`endif

// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART receive FIFO in bursts onto a valid/ready byte sink.
// Optional error counters are enabled with UART_RX_DRAIN_ERRSTAT_EN.
module uart_rx_drain_ctrl #(
    parameter int FIFO_COUNTER_W = 5,
    parameter int REC_WIDTH      = 11,
    parameter int MAX_BURST      = 16
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      enable,
    input  logic [1:0]                trig_level,
    input  logic                      flush,
    input  logic [FIFO_COUNTER_W-1:0] rf_count,
    input  logic [REC_WIDTH-1:0]      rf_data_out,
    input  logic [9:0]                counter_t,
    output logic                      rf_pop,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [7:0]                m_data,
    output logic [2:0]                m_err,
    output logic                      irq_rda,
    output logic                      irq_toi,
    output logic                      busy
`ifdef UART_RX_DRAIN_ERRSTAT_EN
    ,
    input  logic                      cnt_clr,
    output logic [7:0]                cnt_parity,
    output logic [7:0]                cnt_framing,
    output logic [7:0]                cnt_break
`endif
);
    import uart_rx_drain_ctrl_pkg::*;

    localparam int CW = FIFO_COUNTER_W;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_burst_left;
    logic [REC_WIDTH-1:0] r_hold;
    logic                 r_irq_rda;
    logic                 r_irq_toi;

    logic [CW-1:0] w_thr;
    logic          w_thr_hit;
    logic [CW-1:0] w_burst_init;
    logic          w_pop;
    logic          w_toi_set;

    assign w_thr        = CW'(trig_thr(trig_level));
    assign w_thr_hit    = (rf_count >= w_thr);
    assign w_burst_init = (rf_count > CW'(MAX_BURST)) ? CW'(MAX_BURST) : rf_count;
    assign w_toi_set    = (counter_t == 10'd0) && (rf_count != '0);

    // Pop is suppressed by flush/reset in the same cycle and never hits an empty FIFO.
    assign w_pop = (r_state == ST_LOAD) && !flush && !wb_rst_i && (rf_count != '0);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_burst_left <= '0;
            r_hold       <= '0;
            r_irq_rda    <= 1'b0;
            r_irq_toi    <= 1'b0;
        end else begin
            r_irq_rda <= w_thr_hit;

            // A pending timeout survives the pop only if data remains behind it.
            if (flush)
                r_irq_toi <= 1'b0;
            else if (w_toi_set && (!w_pop || (rf_count > CW'(1))))
                r_irq_toi <= 1'b1;
            else if (w_pop)
                r_irq_toi <= 1'b0;

            if (flush) begin
                r_state      <= ST_IDLE;
                r_burst_left <= '0;
                r_hold       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable && (w_thr_hit || r_irq_toi)) begin
                            r_state      <= ST_LOAD;
                            r_burst_left <= w_burst_init;
                        end
                    end
                    ST_LOAD: begin
                        if (w_pop) begin
                            r_hold       <= rf_data_out;
                            r_burst_left <= r_burst_left - CW'(1);
                            r_state      <= ST_PRESENT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PRESENT: begin
                        if (m_ready)
                            r_state <= ((r_burst_left != '0) && (rf_count != '0)) ? ST_LOAD : ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rf_pop  = w_pop;
    assign m_valid = (r_state == ST_PRESENT);
    assign m_data  = r_hold[REC_DATA_HI:REC_DATA_LO];
    assign m_err   = {r_hold[REC_BRK], r_hold[REC_PAR], r_hold[REC_FRM]};
    assign irq_rda = r_irq_rda;
    assign irq_toi = r_irq_toi;
    assign busy    = (r_state != ST_IDLE);

`ifdef UART_RX_DRAIN_ERRSTAT_EN
    logic w_hs;
    assign w_hs = m_valid && m_ready && !flush;

    uart_rx_errstat u_errstat (
        .clk         (clk),
        .rst         (wb_rst_i),
        .clr         (cnt_clr),
        .inc         (w_hs),
        .err         (m_err),
        .cnt_break   (cnt_break),
        .cnt_parity  (cnt_parity),
        .cnt_framing (cnt_framing)
    );
`endif

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Scoreboard bench for uart_rx_drain_ctrl: a queue-based FIFO model feeds the
// DUT, expected bytes are queued at push time and checked by a monitor.
module tb_uart_rx_drain_ctrl;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    trig_level = 2'd0;
    logic          flush = 1'b0;
    logic [CW-1:0] rf_count = '0;
    logic [10:0]   rf_data_out = '0;
    logic [9:0]    counter_t = 10'd100;
    logic          m_ready = 1'b0;
    logic          rf_pop, m_valid, irq_rda, irq_toi, busy;
    logic [7:0]    m_data;
    logic [2:0]    m_err;
`ifdef UART_RX_DRAIN_ERRSTAT_EN
    logic          cnt_clr = 1'b0;
    logic [7:0]    cnt_parity, cnt_framing, cnt_break;
    int            exp_cnt[3] = '{0, 0, 0};
`endif

    always #5 clk = ~clk;

    uart_rx_drain_ctrl dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .trig_level(trig_level),
        .flush(flush), .rf_count(rf_count), .rf_data_out(rf_data_out),
        .counter_t(counter_t), .rf_pop(rf_pop), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_err(m_err), .irq_rda(irq_rda), .irq_toi(irq_toi), .busy(busy)
`ifdef UART_RX_DRAIN_ERRSTAT_EN
        , .cnt_clr(cnt_clr), .cnt_parity(cnt_parity), .cnt_framing(cnt_framing),
        .cnt_break(cnt_break)
`endif
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [10:0] fifo_q[$];
    logic [10:0] pend_q[$];
    logic [10:0] exp_q[$];
    logic        exp_rda = 1'b0;
    logic        exp_toi = 1'b0;
    logic        chk_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_rec = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int thr_of(input logic [1:0] l);
        int t[4] = '{1, 4, 8, 14};
        return t[l];
    endfunction

    // Receiver FIFO model plus the interrupt reference, advanced on the DUT's edge.
    always @(posedge clk) begin
        logic tset;
        tset = (counter_t == 10'd0) && (rf_count != 0);
        exp_rda <= !wb_rst_i && (int'(rf_count) >= thr_of(trig_level));
        exp_toi <= !(wb_rst_i || flush) &&
                   ((tset && (!rf_pop || int'(rf_count) > 1)) || (exp_toi && !rf_pop));
        if (rf_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
        rf_count    <= CW'(fifo_q.size());
        rf_data_out <= (fifo_q.size() != 0) ? fifo_q[0] : 11'd0;
    end

    always @(negedge clk) begin
        logic [10:0] e;
        logic        hs;
        if (chk_en) begin
            chk("irq_rda", irq_rda, exp_rda);
            chk("irq_toi", irq_toi, exp_toi);
            if (rf_pop) chk("pop_nonempty", rf_count != 0, 1);
            if (m_valid) chk("busy_present", busy, 1);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_rec[10:3]);
                chk("stall_err", m_err, prev_rec[2:0]);
            end
`ifdef UART_RX_DRAIN_ERRSTAT_EN
            chk("cnt_break", cnt_break, exp_cnt[0]);
            chk("cnt_parity", cnt_parity, exp_cnt[1]);
            chk("cnt_framing", cnt_framing, exp_cnt[2]);
`endif
            hs = 1'b0;
            e = '0;
            if (m_valid && (flush || wb_rst_i)) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (m_valid && m_ready) begin
                chk("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    hs = 1'b1;
                    chk("m_data", m_data, e[10:3]);
                    chk("m_err", m_err, e[2:0]);
                end
            end
`ifdef UART_RX_DRAIN_ERRSTAT_EN
            if (wb_rst_i || cnt_clr) exp_cnt = '{0, 0, 0};
            else if (hs) begin
                if (e[2]) exp_cnt[0] = (exp_cnt[0] < 255) ? exp_cnt[0] + 1 : 255;
                if (e[1]) exp_cnt[1] = (exp_cnt[1] < 255) ? exp_cnt[1] + 1 : 255;
                if (e[0]) exp_cnt[2] = (exp_cnt[2] < 255) ? exp_cnt[2] + 1 : 255;
            end
`endif
            prev_stall = m_valid && !m_ready && !flush && !wb_rst_i;
            prev_rec   = {m_data, m_err};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] r);
        pend_q.push_back(r);
        exp_q.push_back(r);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!m_valid && k < 50) begin step(); k++; end
        chk({nm, "_valid"}, m_valid, 1);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (k < 1000 && !(exp_q.size() == 0 && pend_q.size() == 0 &&
                             fifo_q.size() == 0 && !busy)) begin
            step();
            k++;
        end
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int pops, bcyc;
        logic [CW-1:0] saved_cnt;
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rf_pop", rf_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", {irq_rda, irq_toi}, 0);
        chk("rst_data", {m_data, m_err}, 0);
        wb_rst_i = 1'b0;
        chk_en   = 1'b1;

        // Trigger at 4: four back-to-back bytes, two cycles each.
        trig_level = 2'd1; enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(11'($urandom_range(0, 2047)));
        pops = 0; bcyc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rf_pop) pops++;
            if (busy) bcyc++;
        end
        chk("burst_pops", pops, 4);
        chk("burst_cycles", bcyc, 8);
        chk("burst_empty", rf_count, 0);

        // Timeout drains a sub-threshold FIFO.
        trig_level = 2'd3;
        for (int i = 0; i < 3; i++) push(11'($urandom_range(0, 2047)));
        repeat (4) step();
        chk("below_thr_idle", busy, 0);
        counter_t = 10'd0;
        step();
        counter_t = 10'd100;
        chk("toi_set", irq_toi, 1);
        wait_idle("toi");
        chk("toi_clear", irq_toi, 0);

        // Stalled sink: byte held stable, no further pops.
        trig_level = 2'd0; m_ready = 1'b0;
        push({8'hA5, 3'b000});
        push({8'h3C, 3'b011});
        wait_valid("stall");
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rf_pop) pops++;
        end
        chk("stall_pops", pops, 0);
        chk("stall_a5", m_data, 8'hA5);
        m_ready = 1'b1;
        wait_idle("stall");

        // Break record.
        m_ready = 1'b0;
        push({8'h00, 3'b100});
        wait_valid("brk");
        chk("brk_err", m_err, 3'b100);
        chk("brk_data", m_data, 8'h00);
        m_ready = 1'b1;
        wait_idle("brk");

        // Flush beats a simultaneous handshake; FIFO head untouched.
        m_ready = 1'b0;
        push({8'h11, 3'b001});
        push({8'h22, 3'b010});
        wait_valid("flush");
        saved_cnt = rf_count;
        flush = 1'b1; m_ready = 1'b1;
        step();
        flush = 1'b0; m_ready = 1'b0;
        chk("flush_valid", m_valid, 0);
        chk("flush_idle", busy, 0);
        chk("flush_count", rf_count, saved_cnt);
        chk("flush_head", rf_data_out, {8'h22, 3'b010});
        m_ready = 1'b1;
        wait_idle("flush");

        // Reset while in LOAD: no pop, everything back to zero.
        push({8'h5A, 3'b000});
        pops = 0;
        while (!(busy && !m_valid) && pops < 20) begin step(); pops++; end
        chk("load_reached", busy && !m_valid, 1);
        wb_rst_i = 1'b1; enable = 1'b0;
        #1;
        chk("rst_load_nopop", rf_pop, 0);
        step();
        chk("rst2_outputs", {rf_pop, m_valid, busy, irq_rda, irq_toi}, 0);
        chk("rst2_data", {m_data, m_err}, 0);
        chk("rst2_fifo", rf_count, 1);
        wb_rst_i = 1'b0;

`ifdef UART_RX_DRAIN_ERRSTAT_EN
        // Break counter saturates.
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int k = 0;
            while (fifo_q.size() + pend_q.size() >= 15 && k < 100) begin step(); k++; end
            push({8'h00, 3'b100});
            step();
        end
        wait_idle("sat");
        chk("cnt_break_sat", cnt_break, 255);
`endif

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) trig_level = 2'($urandom_range(0, 3));
            m_ready   = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            counter_t = ($urandom_range(0, 19) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            flush     = ($urandom_range(0, 39) == 0);
            wb_rst_i  = ($urandom_range(0, 149) == 0);
`ifdef UART_RX_DRAIN_ERRSTAT_EN
            cnt_clr   = ($urandom_range(0, 99) == 0);
`endif
            if ($urandom_range(0, 2) == 0 && fifo_q.size() + pend_q.size() < 15)
                push(11'($urandom_range(0, 2047)));
            step();
        end
        enable = 1'b1; trig_level = 2'd0; m_ready = 1'b1;
        flush = 1'b0; wb_rst_i = 1'b0; counter_t = 10'd100;
`ifdef UART_RX_DRAIN_ERRSTAT_EN
        cnt_clr = 1'b0;
`endif
        wait_idle("rand");
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
